// File: rtl/pc_ras_ctrl.sv
// PC sequencer with redirect/stall/call/ret selection and a circular return-address stack (RAS built when PC_RAS_CTRL_RAS_EN is defined).
// Latency: all outputs registered, next PC visible one cycle after the qualifying inputs.
// Backpressure: stall_i freezes PC and RAS; redirect_i overrides everything and also freezes the RAS.
module pc_ras_ctrl #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [PC_W-1:0]            redirect_pc_i,
  input  logic                       call_i,
  input  logic [PC_W-1:0]            call_target_i,
  input  logic                       ret_i,
  output logic [PC_W-1:0]            pc_o,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_ovf_o,
  output logic                       ras_unf_o
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_seq;

  assign pc_seq = pc_q + PC_W'(INC);
  assign pc_o   = pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

`ifdef PC_RAS_CTRL_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   sp_q;
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q, unf_q;
  logic            push, pop, repl, ovf_d, unf_d;
  logic            has_entry, full;

  // sp_q points at the next free slot; when full it points at the oldest entry.
  assign top_idx   = sp_q - 1'b1;
  assign has_entry = (cnt_q != '0);
  assign full      = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    pc_d  = pc_seq;
    push  = 1'b0;
    pop   = 1'b0;
    repl  = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (call_i) begin
      pc_d = call_target_i;
      // call+ret is a tail call: swap the top return address in place.
      if (ret_i && has_entry) begin
        repl = 1'b1;
      end else begin
        push  = 1'b1;
        ovf_d = full;
      end
    end else if (ret_i) begin
      if (has_entry) begin
        pc_d = ras_q[top_idx];
        pop  = 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) begin
        ras_q[sp_q] <= pc_seq;
        sp_q        <= sp_q + 1'b1;
        if (!full) cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
        sp_q  <= top_idx;
        cnt_q <= cnt_q - 1'b1;
      end else if (repl) begin
        ras_q[top_idx] <= pc_seq;
      end
    end
  end

  assign ras_count_o = cnt_q;
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;
`else
  logic unused_ret;
  assign unused_ret = ret_i;

  always_comb begin
    pc_d = pc_seq;
    if (redirect_i)   pc_d = redirect_pc_i;
    else if (stall_i) pc_d = pc_q;
    else if (call_i)  pc_d = call_target_i;
  end

  assign ras_count_o = '0;
  assign ras_ovf_o   = 1'b0;
  assign ras_unf_o   = 1'b0;
`endif

endmodule

// File: doc/pc_ras_ctrl.md
PC_RAS_CTRL -- requirements
Module: pc_ras_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, the program-counter and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, the value pc_o takes in reset.
REQ-003 SHALL have parameter INC, default 4, the sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, the number of return-address-stack entries; it SHALL be a power of two and at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port stall_i, input, 1 bit: hold the PC (write disable).
REQ-008 SHALL have port redirect_i, input, 1 bit: force the PC to redirect_pc_i (branch resolve or flush).
REQ-009 SHALL have port redirect_pc_i, input, PC_W bits: the redirect target.
REQ-010 SHALL have port call_i, input, 1 bit: the current instruction is a call.
REQ-011 SHALL have port call_target_i, input, PC_W bits: the call destination.
REQ-012 SHALL have port ret_i, input, 1 bit: the current instruction is a return.
REQ-013 SHALL have port pc_o, output, PC_W bits: the registered current PC.
REQ-014 SHALL have port ras_count_o, output, $clog2(RAS_DEPTH)+1 bits: the number of valid RAS entries.
REQ-015 SHALL have ports ras_ovf_o and ras_unf_o, outputs, 1 bit each: registered one-cycle overflow and underflow pulses.

Function
REQ-016 The next PC SHALL be chosen by this priority: redirect_i gives redirect_pc_i; otherwise stall_i holds pc_o; otherwise call_i gives call_target_i; otherwise ret_i with ras_count_o>0 gives the RAS top; otherwise pc_o+INC.
REQ-017 All PC arithmetic SHALL be modulo 2^PC_W (pc_o+INC wraps silently).
REQ-018 When redirect_i or stall_i is high, the RAS, ras_count_o and both flags SHALL be unchanged, except that the flags return to 0.
REQ-019 A call SHALL push pc_o+INC and increment the count.
REQ-020 A push when ras_count_o==RAS_DEPTH SHALL overwrite the oldest entry (circular pointer), hold the count at RAS_DEPTH, and pulse ras_ovf_o.
REQ-021 A ret with count>0 SHALL pop the top entry and decrement the count.
REQ-022 A ret with count==0 SHALL take pc_o+INC, leave the count at 0, and pulse ras_unf_o.
REQ-023 call_i and ret_i high together SHALL replace the top entry with pc_o+INC, leave the count unchanged, and take call_target_i as the next PC.
REQ-024 If the count is 0 when call_i and ret_i are high together, the block SHALL behave as a plain push.
REQ-025 pc_o SHALL change one cycle after the qualifying inputs; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 When rst_i is low, the block SHALL immediately, without waiting for a clock edge, set pc_o=RESET_VEC, ras_count_o=0, ras_ovf_o=0, ras_unf_o=0, clear all RAS entries to 0, and set the stack pointer to 0.
REQ-027 Reset asserted mid-operation SHALL discard any pending push or pop.
REQ-028 After rst_i rises, the first clock edge SHALL follow normal operation.

Configuration
REQ-029 With macro PC_RAS_CTRL_RAS_EN defined, the RAS SHALL be built as specified.
REQ-030 Without PC_RAS_CTRL_RAS_EN, no RAS storage SHALL be built; ret_i SHALL be treated as sequential (pc_o+INC); call_i SHALL still select call_target_i; ras_count_o, ras_ovf_o and ras_unf_o SHALL be constant 0.

Verification
REQ-031 Reset release with no other inputs active -> pc_o=0, then 4, 8, 12 on successive edges; with pc_o=32'hFFFF_FFFC the next value SHALL be 0.
REQ-032 At pc_o=0x100, stall_i=1 for 3 cycles -> pc_o holds 0x100; then redirect_i=1 with stall_i=1 and redirect_pc_i=0x400 -> next pc_o=0x400.
REQ-033 call_i at 0x10 (target 0x200), then call_i at 0x200 (target 0x300), then ret_i twice -> pc_o sequence 0x200, 0x300, 0x204, 0x14; count sequence 1, 2, 1, 0.
REQ-034 Five calls with RAS_DEPTH=4 -> ras_ovf_o pulses once on the fifth call; count stays 4; four rets return the four newest return addresses; a fifth ret -> ras_unf_o pulses and pc_o advances by 4.
REQ-035 call_i and ret_i together at pc_o=0x50 with count=2 (target 0x600) -> pc_o=0x600, count=2, top entry=0x54.
REQ-036 rst_i driven low mid-cycle with count=3 -> pc_o=RESET_VEC and count=0 before the next edge; a build without the macro -> ret_i at 0x80 gives 0x84 and the flags stay 0.
